// File: rtl/flag_commit_ctrl_pkg.sv
// Shared definitions for the status-word commit controller: flag bit
// positions, branch condition codes and branch handshake state encodings.
package flag_commit_ctrl_pkg;

  localparam int NFLAG  = 4;
  localparam int COND_W = 3;

  // Status word order is {C,S,V,Z} on bits [3:0]
  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_C = 3;

  localparam logic [COND_W-1:0] COND_EQ = 3'd0;
  localparam logic [COND_W-1:0] COND_NE = 3'd1;
  localparam logic [COND_W-1:0] COND_CS = 3'd2;
  localparam logic [COND_W-1:0] COND_CC = 3'd3;
  localparam logic [COND_W-1:0] COND_MI = 3'd4;
  localparam logic [COND_W-1:0] COND_PL = 3'd5;
  localparam logic [COND_W-1:0] COND_VS = 3'd6;
  localparam logic [COND_W-1:0] COND_LT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } br_state_t;

endpackage

// File: rtl/flag_commit_ctrl_cond_eval.sv
// Branch condition evaluator: maps a condition code and a flag word to a
// taken decision. Purely combinational so a predictor checker can reuse it.
module flag_commit_ctrl_cond_eval
  import flag_commit_ctrl_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [NFLAG-1:0]  flags,
  output logic              taken
);

  // Decode the condition against the supplied flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken =  flags[FLAG_Z];
      COND_NE: taken = ~flags[FLAG_Z];
      COND_CS: taken =  flags[FLAG_C];
      COND_CC: taken = ~flags[FLAG_C];
      COND_MI: taken =  flags[FLAG_S];
      COND_PL: taken = ~flags[FLAG_S];
      COND_VS: taken =  flags[FLAG_V];
      COND_LT: taken =  flags[FLAG_S] ^ flags[FLAG_V];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_commit_ctrl.sv
// Status word owner: delays EX flags through PIPE_DEPTH stages to commit,
// forwards the youngest pending flags, and resolves conditional branches
// with a req/ack handshake that waits out flag-setting instructions in EX.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no branch outstanding, or a new request seen this cycle
// ST_WAIT | request held off: EX instruction will still write flags
// ST_RESP | br_ack high for this single cycle, br_taken valid
//
// PIPE_DEPTH is meaningful in the range 1..4.
module flag_commit_ctrl
  import flag_commit_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [NFLAG-1:0]  ex_flag_we,
  input  logic [NFLAG-1:0]  ex_flags,
  input  logic              stall,
  input  logic              flush,
  input  logic              psw_we,
  input  logic [NFLAG-1:0]  psw_wdata,
  input  logic              br_req,
  input  logic [COND_W-1:0] br_cond,
  output logic [NFLAG-1:0]  psw_q,
  output logic [NFLAG-1:0]  fwd_flags,
  output logic              flags_pend,
  output logic              br_busy,
  output logic              br_ack,
  output logic              br_taken
);

  logic [PIPE_DEPTH-1:0]            st_vld;
  logic [PIPE_DEPTH-1:0][NFLAG-1:0] st_we;
  logic [PIPE_DEPTH-1:0][NFLAG-1:0] st_fl;

  br_state_t state;
  logic      hazard;
  logic      eval_taken;

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
    logic             vld;
    logic [NFLAG-1:0] we;
    logic [NFLAG-1:0] fl;
    logic             src_vld;
    logic [NFLAG-1:0] src_we;
    logic [NFLAG-1:0] src_fl;

    if (i == 0) begin : g_src_ex
      assign src_vld = ex_valid;
      assign src_we  = ex_flag_we;
      assign src_fl  = ex_flags;
    end else begin : g_src_prev
      assign src_vld = st_vld[i-1];
      assign src_we  = st_we[i-1];
      assign src_fl  = st_fl[i-1];
    end

    // Shift when not stalled; flush kills everything younger than the last stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld <= 1'b0;
        we  <= '0;
        fl  <= '0;
      end else if (!stall) begin
        vld <= src_vld & ~flush;
        we  <= src_we;
        fl  <= src_fl;
      end else if (flush && (i < PIPE_DEPTH - 1)) begin
        vld <= 1'b0;
      end
    end

    assign st_vld[i] = vld;
    assign st_we[i]  = we;
    assign st_fl[i]  = fl;
  end

  // Architectural word: software write beats a same-cycle commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psw_q <= '0;
    end else if (psw_we) begin
      psw_q <= psw_wdata;
    end else if (!stall && st_vld[PIPE_DEPTH-1]) begin
      psw_q <= (psw_q & ~st_we[PIPE_DEPTH-1]) |
               (st_fl[PIPE_DEPTH-1] & st_we[PIPE_DEPTH-1]);
    end
  end

  // Overlay pending stages oldest-first so the youngest writer of a bit wins
  always_comb begin
    fwd_flags = psw_q;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      if (st_vld[i]) begin
        fwd_flags = (fwd_flags & ~st_we[i]) | (st_fl[i] & st_we[i]);
      end
    end
  end

  // Any valid stage that will still write at least one flag
  always_comb begin
    flags_pend = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (st_vld[i] && (|st_we[i])) flags_pend = 1'b1;
    end
  end

  assign hazard  = ex_valid & (|ex_flag_we) & ~flush;
  assign br_busy = br_req & ~br_ack;

  flag_commit_ctrl_cond_eval u_cond_eval (
    .cond  (br_cond),
    .flags (fwd_flags),
    .taken (eval_taken)
  );

  // Branch resolution handshake; RESP always returns to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      br_ack   <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      br_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (br_req) begin
            if (hazard) begin
              state <= ST_WAIT;
            end else begin
              state    <= ST_RESP;
              br_ack   <= 1'b1;
              br_taken <= eval_taken;
            end
          end
        end
        ST_WAIT: begin
          if (flush || !br_req) begin
            state <= ST_IDLE;
          end else if (!hazard) begin
            state    <= ST_RESP;
            br_ack   <= 1'b1;
            br_taken <= eval_taken;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
